// File: rtl/adder_bist.sv
// ---------------------------------------------------------------------------
// adder_bist
//
// Built-in self-test sequencer for a 4-bit adder with carry-in and carry-out.
// A run walks all 512 input combinations {cin,a,b}. Each vector is held on
// the adder for SETTLE_CYCLES cycles. It is then checked for one cycle
// against the arithmetic sum. The block counts mismatching vectors and
// records the first one that failed.
//
// Parameters
//   SETTLE_CYCLES   cycles each vector is held before it is checked (1..15)
//
// Ports
//   clk             single clock, rising edge
//   rst             asynchronous active-high reset
//   start           single-cycle request to begin a run (IDLE/DONE only)
//   dut_a, dut_b    adder operands
//   dut_cin         adder carry-in
//   dut_sum         adder sum response
//   dut_cout        adder carry-out response
//   busy            high while a run is in progress
//   done            high once a run has completed, held until restart/reset
//   pass            valid with done; 1 means no mismatches
//   err_count       mismatching vectors in the current or last run
//   first_err_vec   {cin,a,b} of the first mismatching vector
//   first_err_valid first_err_vec has been captured
// ---------------------------------------------------------------------------
module adder_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    output logic       dut_cin,
    input  logic [3:0] dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_err_vec,
    output logic       first_err_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    // The settle counter counts down to zero, so it is loaded with one less
    // than the hold length each time WAIT is entered.
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [8:0] LAST_VEC      = 9'd511;

    state_t     state_q, state_d;
    logic [8:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [9:0] errCount_q, errCount_d;
    logic [8:0] firstErrVec_q, firstErrVec_d;
    logic       firstErrValid_q, firstErrValid_d;

    logic [4:0] expected;
    logic       mismatch;

    // The vector register drives the adder directly: vec = {cin, a, b}.
    assign dut_cin         = vec_q[8];
    assign dut_a           = vec_q[7:4];
    assign dut_b           = vec_q[3:0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = errCount_q;
    assign first_err_vec   = firstErrVec_q;
    assign first_err_valid = firstErrValid_q;

    // Reference sum of the current vector, widened to 5 bits so that the
    // carry-out is compared together with the sum bits.
    assign expected = {1'b0, vec_q[7:4]} + {1'b0, vec_q[3:0]} + {4'b0000, vec_q[8]};
    assign mismatch = (expected != {dut_cout, dut_sum});

    // State and result registers. Reset clears everything at once, so a run
    // that is interrupted leaves no partial result behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            vec_q           <= '0;
            settle_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            errCount_q      <= '0;
            firstErrVec_q   <= '0;
            firstErrValid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            vec_q           <= vec_d;
            settle_q        <= settle_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            errCount_q      <= errCount_d;
            firstErrVec_q   <= firstErrVec_d;
            firstErrValid_q <= firstErrValid_d;
        end
    end

    // Next-state logic. By default every register holds its value. In DONE
    // this keeps vec at 511 and the results stable. start is only acted on
    // from IDLE or DONE.
    always_comb begin
        state_d         = state_q;
        vec_d           = vec_q;
        settle_d        = settle_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        errCount_d      = errCount_q;
        firstErrVec_d   = firstErrVec_q;
        firstErrValid_d = firstErrValid_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d         = WAIT;
                    vec_d           = '0;
                    settle_d        = SETTLE_RELOAD;
                    busy_d          = 1'b1;
                    done_d          = 1'b0;
                    pass_d          = 1'b0;
                    errCount_d      = '0;
                    firstErrVec_d   = '0;
                    firstErrValid_d = 1'b0;
                end
            end

            WAIT: begin
                if (settle_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            CHECK: begin
                // err_count cannot reach its 10-bit limit: at most 512 vectors.
                if (mismatch) begin
                    errCount_d = errCount_q + 10'd1;
                    if (!firstErrValid_q) begin
                        firstErrVec_d   = vec_q;
                        firstErrValid_d = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    // Use the updated count so that a failure on the last
                    // vector is reflected in pass.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (errCount_d == 10'd0);
                end else begin
                    state_d  = WAIT;
                    vec_d    = vec_q + 9'd1;
                    settle_d = SETTLE_RELOAD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_bist.sv
// ---------------------------------------------------------------------------
// tb_adder_bist
//
// Two BIST instances: one with SETTLE_CYCLES=1 and one with SETTLE_CYCLES=3.
// Each drives a behavioural adder. The adder can be switched to a faulty
// mode: carry-out stuck at 0, or sum bit 0 inverted. When a run is launched,
// the stimulus pushes the expected run result into a per-instance queue. A
// monitor pops that result on each rising edge of done and compares it.
// ---------------------------------------------------------------------------
module tb_adder_bist;

    typedef struct {
        logic       pass;
        logic [9:0] errs;
        logic       fev;
        logic [8:0] fvec;
        int         cycles;
    } result_t;

    logic       clk;
    logic       rst;
    logic       start1, start3;
    logic [3:0] dutA1, dutB1, dutSum1, dutA3, dutB3, dutSum3;
    logic       dutCin1, dutCout1, dutCin3, dutCout3;
    logic       busy1, done1, pass1, fev1;
    logic       busy3, done3, pass3, fev3;
    logic [9:0] errCount1, errCount3;
    logic [8:0] firstVec1, firstVec3;

    // Fault mode of each adder: 0 = correct, 1 = cout stuck 0, 2 = sum[0] inverted.
    int mode1, mode3;

    int testsRun;
    int testsFailed;

    result_t sb1[$];
    result_t sb3[$];

    adder_bist #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .dut_a(dutA1), .dut_b(dutB1), .dut_cin(dutCin1),
        .dut_sum(dutSum1), .dut_cout(dutCout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(errCount1),
        .first_err_vec(firstVec1), .first_err_valid(fev1)
    );

    adder_bist #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .dut_a(dutA3), .dut_b(dutB3), .dut_cin(dutCin3),
        .dut_sum(dutSum3), .dut_cout(dutCout3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(errCount3),
        .first_err_vec(firstVec3), .first_err_valid(fev3)
    );

    // Behavioural adders with optional fault injection.
    logic [4:0] raw1, raw3;
    assign raw1     = {1'b0, dutA1} + {1'b0, dutB1} + {4'b0000, dutCin1};
    assign raw3     = {1'b0, dutA3} + {1'b0, dutB3} + {4'b0000, dutCin3};
    assign dutSum1  = raw1[3:0] ^ {3'b000, (mode1 == 2)};
    assign dutCout1 = (mode1 == 1) ? 1'b0 : raw1[4];
    assign dutSum3  = raw3[3:0] ^ {3'b000, (mode3 == 2)};
    assign dutCout3 = (mode3 == 1) ? 1'b0 : raw3[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse start for one cycle on the selected instance.
    task automatic applyStimulus(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic waitDone(input int which, input int limit);
        int n;
        n = 0;
        while (((which == 1) ? done1 : done3) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) checkOutput($sformatf("done%0d timeout", which), 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor for the SETTLE_CYCLES=1 instance.
    int  busyCnt1;
    logic prevBusy1, prevDone1;
    initial begin
        busyCnt1 = 0; prevBusy1 = 1'b0; prevDone1 = 1'b0;
    end
    always @(negedge clk) begin
        result_t e;
        if (busy1 && !prevBusy1) busyCnt1 = 0;
        if (done1 && !prevDone1) begin
            if (sb1.size() == 0) begin
                checkOutput("dut1 unexpected done", 1, 0);
            end else begin
                e = sb1.pop_front();
                checkOutput("dut1 pass", int'(pass1), int'(e.pass));
                checkOutput("dut1 err_count", int'(errCount1), int'(e.errs));
                checkOutput("dut1 first_err_valid", int'(fev1), int'(e.fev));
                checkOutput("dut1 first_err_vec", int'(firstVec1), int'(e.fvec));
                checkOutput("dut1 run cycles", busyCnt1, e.cycles);
            end
        end
        if (busy1) busyCnt1++;
        prevBusy1 = busy1;
        prevDone1 = done1;
    end

    // Monitor for the SETTLE_CYCLES=3 instance, including the vector hold time.
    int  busyCnt3, holdCnt3, holdBad3;
    logic [8:0] prevVec3;
    logic prevBusy3, prevDone3;
    initial begin
        busyCnt3 = 0; holdCnt3 = 0; holdBad3 = 0; prevVec3 = '0;
        prevBusy3 = 1'b0; prevDone3 = 1'b0;
    end
    always @(negedge clk) begin
        result_t e;
        if (busy3 && !prevBusy3) begin
            busyCnt3 = 0;
            holdCnt3 = 0;
            holdBad3 = 0;
            prevVec3 = {dutCin3, dutA3, dutB3};
        end
        if (done3 && !prevDone3) begin
            if (holdCnt3 != 4) holdBad3++;
            if (sb3.size() == 0) begin
                checkOutput("dut3 unexpected done", 1, 0);
            end else begin
                e = sb3.pop_front();
                checkOutput("dut3 pass", int'(pass3), int'(e.pass));
                checkOutput("dut3 err_count", int'(errCount3), int'(e.errs));
                checkOutput("dut3 first_err_valid", int'(fev3), int'(e.fev));
                checkOutput("dut3 run cycles", busyCnt3, e.cycles);
                checkOutput("dut3 vectors not held 4 cycles", holdBad3, 0);
            end
        end
        if (busy3) begin
            busyCnt3++;
            if ({dutCin3, dutA3, dutB3} == prevVec3) begin
                holdCnt3++;
            end else begin
                if (holdCnt3 != 4) holdBad3++;
                holdCnt3 = 1;
                prevVec3 = {dutCin3, dutA3, dutB3};
            end
        end
        prevBusy3 = busy3;
        prevDone3 = done3;
    end

    task automatic pushExp1(input logic p, input int errs, input logic fev, input int fvec);
        result_t r;
        r.pass = p; r.errs = 10'(errs); r.fev = fev; r.fvec = 9'(fvec); r.cycles = 1024;
        sb1.push_back(r);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " vec"}, int'({dutCin1, dutA1, dutB1}), 0);
        checkOutput({tag, " busy"}, int'(busy1), 0);
        checkOutput({tag, " done"}, int'(done1), 0);
        checkOutput({tag, " pass"}, int'(pass1), 0);
        checkOutput({tag, " err_count"}, int'(errCount1), 0);
        checkOutput({tag, " first_err_vec"}, int'(firstVec1), 0);
        checkOutput({tag, " first_err_valid"}, int'(fev1), 0);
    endtask

    initial begin
        result_t r3;
        int n;
        testsRun = 0; testsFailed = 0;
        mode1 = 0; mode3 = 0;
        start1 = 1'b0; start3 = 1'b0;
        rst = 1'b1;

        // start during reset must be ignored.
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        #1 checkAllZero("reset");
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle after reset busy", int'(busy1), 0);
        checkOutput("idle after reset done", int'(done1), 0);

        // Correct adder.
        pushExp1(1'b1, 0, 1'b0, 0);
        applyStimulus(1);
        waitDone(1, 1100);
        repeat (5) @(negedge clk);
        checkOutput("done held", int'(done1), 1);
        checkOutput("pass held", int'(pass1), 1);
        checkOutput("vec held at 511", int'({dutCin1, dutA1, dutB1}), 511);

        // cout stuck at 0, with a start pulse mid-run that must be ignored.
        mode1 = 1;
        pushExp1(1'b0, 256, 1'b1, 9'h01F);
        applyStimulus(1);
        repeat (300) @(negedge clk);
        applyStimulus(1);
        waitDone(1, 1100);

        // Restart from DONE clears the results on the next edge.
        mode1 = 2;
        pushExp1(1'b0, 512, 1'b1, 0);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        checkOutput("restart err_count", int'(errCount1), 0);
        checkOutput("restart first_err_valid", int'(fev1), 0);
        checkOutput("restart busy", int'(busy1), 1);
        checkOutput("restart done", int'(done1), 0);
        waitDone(1, 1100);

        // Reset between edges while vec=100 abandons the run.
        mode1 = 0;
        applyStimulus(1);
        n = 0;
        while ({dutCin1, dutA1, dutB1} != 9'd100 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) checkOutput("vec 100 timeout", 0, 1);
        #1 rst = 1'b1;
        #1 checkAllZero("async reset");
        #1 rst = 1'b0;
        pushExp1(1'b1, 0, 1'b0, 0);
        applyStimulus(1);
        waitDone(1, 1100);

        // SETTLE_CYCLES=3 with a correct adder.
        r3.pass = 1'b1; r3.errs = '0; r3.fev = 1'b0; r3.fvec = '0; r3.cycles = 2048;
        sb3.push_back(r3);
        applyStimulus(3);
        waitDone(3, 2200);

        checkOutput("dut1 scoreboard drained", sb1.size(), 0);
        checkOutput("dut3 scoreboard drained", sb3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 1..15: clock cycles a vector is held on the DUT before its response is sampled.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a single-cycle request to begin a self-test run.
REQ-005 SHALL have port dut_a, output, 4, DUT operand a.
REQ-006 SHALL have port dut_b, output, 4, DUT operand b.
REQ-007 SHALL have port dut_cin, output, 1, DUT carry-in.
REQ-008 SHALL have port dut_sum, input, 4, DUT sum response.
REQ-009 SHALL have port dut_cout, input, 1, DUT carry-out response.
REQ-010 SHALL have port busy, output, 1, high while a run is in progress.
REQ-011 SHALL have port done, output, 1, high once a run has completed, held until restart or reset.
REQ-012 SHALL have port pass, output, 1, valid when done is high; 1 means zero mismatches.
REQ-013 SHALL have port err_count, output, 10, number of mismatching vectors in the current or last run.
REQ-014 SHALL have port first_err_vec, output, 9, the {cin,a,b} value of the first mismatching vector.
REQ-015 SHALL have port first_err_valid, output, 1, high once first_err_vec has been captured.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT, CHECK and DONE.
REQ-017 SHALL hold a 9-bit vector register vec that drives {dut_cin,dut_a,dut_b} directly, with vec[8]=cin, vec[7:4]=a and vec[3:0]=b.
REQ-018 IDLE or DONE with start=1 SHALL, on the next edge, move to WAIT with vec=0, clear err_count, first_err_vec and first_err_valid, and set busy=1 and done=0.
REQ-019 start SHALL be ignored in WAIT and CHECK.
REQ-020 WAIT SHALL last exactly SETTLE_CYCLES cycles, counted by a 4-bit settle counter reloaded on each entry, and then move to CHECK.
REQ-021 CHECK SHALL last one cycle: expected = vec[7:4] + vec[3:0] + vec[8], 5-bit unsigned, compared against {dut_cout,dut_sum}; any bit difference is a mismatch.
REQ-022 On a mismatch, err_count SHALL increment by 1; it never wraps, since its maximum is 512.
REQ-023 On a mismatch with first_err_valid=0, CHECK SHALL also capture first_err_vec=vec and set first_err_valid=1.
REQ-024 CHECK with vec!=511 SHALL increment vec and return to WAIT.
REQ-025 CHECK with vec=511 SHALL go to DONE and set busy=0, done=1 and pass=(final err_count==0), counting a mismatch on vector 511 itself.
REQ-026 In DONE, vec SHALL hold at 511 and all result outputs SHALL hold their values.
REQ-027 pass SHALL be 0 whenever done=0.
REQ-028 Run length SHALL be 512*(SETTLE_CYCLES+1) cycles from the first WAIT cycle to the first DONE cycle.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force state IDLE, vec=0, dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0 and settle counter=0.
REQ-030 Reset mid-run SHALL abandon the run with no partial result retained.
REQ-031 After reset is released, the block SHALL stay in IDLE until start is seen.
REQ-032 start asserted during rst SHALL be ignored.

Verification
REQ-033 Correct adder model, SETTLE_CYCLES=1, one-cycle start pulse -> done rises 1024 cycles after the first WAIT cycle, with pass=1, err_count=0 and first_err_valid=0.
REQ-034 DUT with dut_cout stuck at 0 -> err_count=256 (120 with cin=0 plus 136 with cin=1), pass=0, first_err_vec=9'h01F (cin=0, a=1, b=15).
REQ-035 DUT with sum bit 0 inverted -> err_count=512, first_err_vec=0, pass=0.
REQ-036 rst pulsed while vec=100, between clock edges -> all outputs read 0 before the next edge; a later start runs the full 512 vectors from vec=0 and ends with a correct result.
REQ-037 start pulsed while busy=1 has no effect; start pulsed in DONE restarts and clears err_count to 0 and first_err_valid to 0 on the next edge.
REQ-038 SETTLE_CYCLES=3 with a correct DUT -> done after 2048 cycles and each vector held 4 cycles on dut_a, dut_b and dut_cin.
